// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path constants and types for the prefetch queue and its users.
package fetch_queue_pkg;

    // Pipeline-wide PC value after reset.
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    // sll $0,$0,0: what decode sees when nothing has been fetched.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // One fetched instruction together with its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrapping circular-buffer pointer: clear has priority over increment.
module fq_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inc,
    input  logic                     clr,
    output logic [$clog2(DEPTH)-1:0] ptr
);
    import fetch_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear to 0, or step with wrap from DEPTH-1 back to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode. Show-ahead output,
// in-order push/pop, flush on redirect, sticky overflow flag.
module fetch_queue #(
    parameter int unsigned         DEPTH     = 4,
    parameter int unsigned         PC_W      = 32,
    parameter int unsigned         INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       in_ready,
    input  logic                       flush,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow_err
);
    import fetch_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             overflow_q;
    logic             push;
    logic             pop;

    // Handshakes depend only on registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    fq_ptr #(
        .DEPTH (DEPTH)
    ) u_wp (
        .clk   (clk),
        .reset (reset),
        .inc   (push & ~flush),
        .clr   (flush),
        .ptr   (wp)
    );

    fq_ptr #(
        .DEPTH (DEPTH)
    ) u_rp (
        .clk   (clk),
        .reset (reset),
        .inc   (pop & ~flush),
        .clr   (flush),
        .ptr   (rp)
    );

    // Occupancy next-state: flush wins, otherwise push/pop adjust by one.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Sticky overflow: any refused push attempt; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            pc_mem[wp]    <= in_pc;
            instr_mem[wp] <= in_instr;
        end
    end

    // Show-ahead head; an empty queue presents PC 0 and a NOP to decode.
    always_comb begin
        out_pc    = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc    = pc_mem[rp];
            out_instr = instr_mem[rp];
        end
    end

    assign count        = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed steps plus random traffic,
// compared against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    fetch_entry_t mq[$];
    logic         m_ovf;

    fetch_queue #(
        .DEPTH     (DEPTH),
        .PC_W      (32),
        .INSTR_W   (32),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_ready    (out_ready),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the reference model.
    task automatic check_model();
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
        e_instr = (mq.size() != 0) ? mq[0].instr : NOP_INSTR;
        check("count", 64'(count), 64'(mq.size()));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        check("out_pc", 64'(out_pc), 64'(e_pc));
        check("out_instr", 64'(out_instr), 64'(e_instr));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
    endtask

    // Drive one cycle, advance the model by the queue rules, then check.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rst);
        bit do_push;
        bit do_pop;
        fetch_entry_t e;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (iv && mq.size() == DEPTH) m_ovf = 1'b1;
            if (fl) begin
                mq.delete();
            end else begin
                do_push = iv && (mq.size() < DEPTH);
                do_pop  = ordy && (mq.size() != 0);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    e.pc    = pc;
                    e.instr = ins;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        int idx;
        int npop;
        bit acc;
        clk       = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        m_ovf     = 1'b0;

        // Reset then idle.
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        check("idle_count", 64'(count), 64'd0);
        check("idle_instr", 64'(out_instr), 64'h0);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Single push, then pop one cycle later.
        step(1, RESET_PC, 32'h2401_0001, 0, 0, 0);
        check("single_pc", 64'(out_pc), 64'h3000);
        check("single_instr", 64'(out_instr), 64'h2401_0001);
        step(0, 0, 0, 1, 0, 0);
        check("single_drained", 64'(out_valid), 64'd0);

        // Fill to DEPTH, then a refused fifth push.
        for (int i = 0; i < 4; i++) step(1, RESET_PC + 32'(4 * i), 32'h1000 + 32'(i), 0, 0, 0);
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        step(1, 32'h3010, 32'h1004, 0, 0, 0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        check("ovf_head", 64'(out_pc), 64'h3000);

        // Full with push and pop together: pop only, then the push lands.
        step(1, 32'h3010, 32'h1004, 1, 0, 0);
        check("fullpp_count", 64'(count), 64'd3);
        check("fullpp_head", 64'(out_pc), 64'h3004);
        step(1, 32'h3010, 32'h1004, 0, 0, 0);
        check("fullpp_push", 64'(count), 64'd4);

        // Drain, then stream 10 entries with out_ready toggling.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        idx  = 0;
        npop = 0;
        for (int cyc = 0; cyc < 60 && npop < 10; cyc++) begin
            if (out_valid && cyc[0]) begin
                check("stream_order", 64'(out_pc), 64'(32'h3000 + 32'(4 * npop)));
                npop++;
            end
            acc = (idx < 10) && in_ready;
            step(idx < 10, 32'h3000 + 32'(4 * idx), 32'hA000 + 32'(idx), cyc[0], 0, 0);
            check("stream_bound", 64'(count <= 3'd4), 64'd1);
            if (acc) idx++;
        end
        check("stream_total", 64'(npop), 64'd10);

        // Flush with push and pop in the same cycle.
        for (int i = 0; i < 3; i++) step(1, 32'h5000 + 32'(4 * i), 32'h0, 0, 0, 0);
        step(1, 32'h4000, 32'hBEEF, 1, 1, 0);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        step(1, 32'h4000, 32'hBEEF, 0, 0, 0);
        check("post_flush_head", 64'(out_pc), 64'h4000);
        step(1, 32'h4004, 32'h0, 1, 1, 1);
        check("reset_flush_ovf", 64'(overflow_err), 64'd0);
        check("reset_flush_count", 64'(count), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, $urandom, $urandom, $urandom % 2,
                 ($urandom % 20) == 0, ($urandom % 150) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
